instruction_handler: RTL and testbench



---
 rtl/instruction_handler.sv | 151 +++++++++++++++
 tb/tb_instruction_handler.sv | 129 ++++++++++++
 2 files changed

// File: rtl/instruction_handler.sv
`default_nettype none
// ============================================================================
// Module   : instruction_handler
// Brief    : Registered execute stage of a 16-bit Nandgame-style CPU.
//            Handles operand select, ALU, jump condition and output register.
// Revision : 1.0
// ============================================================================

module instruction_handler_mux (
    input  logic        sel,
    input  logic [15:0] in0,
    input  logic [15:0] in1,
    output logic [15:0] out
);
    assign out = sel ? in1 : in0;
endmodule

module instruction_handler_alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        u,
    input  logic        op1,
    input  logic        op0,
    input  logic        zx,
    input  logic        sw,
    output logic [15:0] r
);
    logic [15:0] x_sw;
    logic [15:0] y_sw;
    logic [15:0] x_z;

    // Swap happens before zeroing, so zx always clears whichever operand ends up as X.
    assign x_sw = sw ? y : x;
    assign y_sw = sw ? x : y;
    assign x_z  = zx ? 16'h0000 : x_sw;

    always_comb begin
        r = 16'h0000;
        unique case ({u, op1, op0})
            3'b100:  r = x_z + y_sw;
            3'b101:  r = x_z + 16'h0001;
            3'b110:  r = x_z - y_sw;
            3'b111:  r = x_z - 16'h0001;
            3'b000:  r = x_z & y_sw;
            3'b001:  r = x_z | y_sw;
            3'b010:  r = x_z ^ y_sw;
            default: r = ~x_z;
        endcase
    end
endmodule

module instruction_handler_cond (
    input  logic [15:0] r,
    input  logic        lt,
    input  logic        eq,
    input  logic        gt,
    output logic        j
);
    logic is_neg;
    logic is_zero;

    assign is_neg  = r[15];
    assign is_zero = (r == 16'h0000);
    assign j       = (lt & is_neg) | (eq & is_zero) | (gt & ~is_neg & ~is_zero);
endmodule

module instruction_handler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] I,
    input  logic [15:0] A,
    input  logic [15:0] D,
    input  logic [15:0] addr_A,
    output logic [15:0] R,
    output logic        a,
    output logic        d,
    output logic        addr_a,
    output logic        j
);
    logic [15:0] y_sel;
    logic [15:0] alu_r;
    logic        jump;

    logic [15:0] result_d, result_q;
    logic        we_a_d, we_a_q;
    logic        we_d_d, we_d_q;
    logic        we_m_d, we_m_q;
    logic        jump_d, jump_q;

    // Opcode class bits I[15:13] and I[11] do not influence this stage.
    logic unused_bits;
    assign unused_bits = ^{I[15:13], I[11]};

    instruction_handler_mux u_mux (
        .sel (I[12]),
        .in0 (A),
        .in1 (addr_A),
        .out (y_sel)
    );

    instruction_handler_alu u_alu (
        .x   (D),
        .y   (y_sel),
        .u   (I[10]),
        .op1 (I[9]),
        .op0 (I[8]),
        .zx  (I[7]),
        .sw  (I[6]),
        .r   (alu_r)
    );

    instruction_handler_cond u_cond (
        .r  (alu_r),
        .lt (I[2]),
        .eq (I[1]),
        .gt (I[0]),
        .j  (jump)
    );

    always_comb begin
        result_d = alu_r;
        we_a_d   = I[5];
        we_d_d   = I[4];
        we_m_d   = I[3];
        jump_d   = jump;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= 16'h0000;
            we_a_q   <= 1'b0;
            we_d_q   <= 1'b0;
            we_m_q   <= 1'b0;
            jump_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            we_a_q   <= we_a_d;
            we_d_q   <= we_d_d;
            we_m_q   <= we_m_d;
            jump_q   <= jump_d;
        end
    end

    assign R      = result_q;
    assign a      = we_a_q;
    assign d      = we_d_q;
    assign addr_a = we_m_q;
    assign j      = jump_q;
endmodule

`default_nettype wire

// File: tb/tb_instruction_handler.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_handler
// Brief    : Directed self-checking bench for instruction_handler.
// Revision : 1.0
// ============================================================================

module tb_instruction_handler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] I, A, D, addr_A;
    logic [15:0] R;
    logic        a, d, addr_a, j;

    int n_checks = 0;
    int n_errors = 0;

    instruction_handler dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .I      (I),
        .A      (A),
        .D      (D),
        .addr_A (addr_A),
        .R      (R),
        .a      (a),
        .d      (d),
        .addr_a (addr_a),
        .j      (j)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [15:0] i_w, input logic [15:0] a_w,
                       input logic [15:0] d_w, input logic [15:0] m_w);
        I = i_w; A = a_w; D = d_w; addr_A = m_w;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic [15:0] r_e,
                              input logic [2:0] dst_e, input logic j_e);
        check({tag, ".R"},   R, r_e);
        check({tag, ".dst"}, {13'd0, a, d, addr_a}, {13'd0, dst_e});
        check({tag, ".j"},   {15'd0, j}, {15'd0, j_e});
    endtask

    // Sweep index {sw, zx, u, op1, op0}; X=D=0x00F0, Y=A=0x0F3C.
    logic [15:0] sweep_exp [32];

    initial begin
        sweep_exp = '{
            16'h0030, 16'h0FFC, 16'h0FCC, 16'hFF0F, 16'h102C, 16'h00F1, 16'hF1B4, 16'h00EF,
            16'h0000, 16'h0F3C, 16'h0F3C, 16'hFFFF, 16'h0F3C, 16'h0001, 16'hF0C4, 16'hFFFF,
            16'h0030, 16'h0FFC, 16'h0FCC, 16'hF0C3, 16'h102C, 16'h0F3D, 16'h0E4C, 16'h0F3B,
            16'h0000, 16'h00F0, 16'h00F0, 16'hFFFF, 16'h00F0, 16'h0001, 16'hFF10, 16'hFFFF
        };

        rst_n = 1'b1;
        I = 16'($urandom); A = 16'($urandom); D = 16'($urandom); addr_A = 16'($urandom);
        #1 rst_n = 1'b0;
        #1;
        expect_all("reset", 16'h0000, 3'b000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run(16'hE590, 16'h0007, 16'h0009, 16'h000D);
        expect_all("zx_inc", 16'h0001, 3'b010, 1'b0);
        run(16'hE018, 16'h0006, 16'h0005, 16'h0000);
        expect_all("and_2dst", 16'h0004, 3'b011, 1'b0);
        run(16'hF4A3, 16'h1111, 16'h0000, 16'h002A);
        expect_all("mem_gt", 16'h002A, 3'b100, 1'b1);
        run(16'hF4A6, 16'h1111, 16'h0000, 16'h002A);
        expect_all("mem_lteq", 16'h002A, 3'b100, 1'b0);
        run(16'hE760, 16'h002A, 16'h0001, 16'h0002);
        expect_all("sw_dec", 16'h0029, 3'b100, 1'b0);
        run(16'hE762, 16'h0001, 16'h0002, 16'hFFFF);
        expect_all("sw_dec_eq", 16'h0000, 3'b100, 1'b1);

        // Destination d only, condition lt: j follows the sign of each result.
        for (int k = 0; k < 32; k++) begin
            logic [4:0] kb;
            kb = 5'(k);
            run({3'b111, 1'b0, 1'b0, kb[2], kb[1], kb[0], kb[3], kb[4], 3'b010, 3'b100},
                16'h0F3C, 16'h00F0, 16'hAAAA);
            check($sformatf("sweep%0d.R", k), R, sweep_exp[k]);
            check($sformatf("sweep%0d.j", k), {15'd0, j}, {15'd0, sweep_exp[k][15]});
        end

        run(16'hE502, 16'h0000, 16'hFFFF, 16'h0000);
        expect_all("wrap_inc_eq", 16'h0000, 3'b000, 1'b1);
        run(16'hE704, 16'h0000, 16'h0000, 16'h0000);
        expect_all("wrap_dec_lt", 16'hFFFF, 3'b000, 1'b1);
        run(16'hE504, 16'h0000, 16'h7FFF, 16'h0000);
        expect_all("wrap_neg", 16'h8000, 3'b000, 1'b1);
        run(16'hE507, 16'h0000, 16'h1234, 16'h0000);
        expect_all("cond111", 16'h1235, 3'b000, 1'b1);

        run(16'h0D90, 16'h0007, 16'h0009, 16'h000D);
        expect_all("ign_zx_inc", 16'h0001, 3'b010, 1'b0);
        run(16'h1CA3, 16'h1111, 16'h0000, 16'h002A);
        expect_all("ign_mem_gt", 16'h002A, 3'b100, 1'b1);
        run(16'h6F62, 16'h0001, 16'h0002, 16'hFFFF);
        expect_all("ign_sw_dec", 16'h0000, 3'b100, 1'b1);

        // Asynchronous reset between edges clears the pending result at once.
        run(16'hF4A3, 16'h0000, 16'h0000, 16'h002A);
        #2 rst_n = 1'b0;
        #1;
        expect_all("midreset", 16'h0000, 3'b000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run(16'hE018, 16'h0006, 16'h0005, 16'h0000);
        expect_all("post_reset", 16'h0004, 3'b011, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
